// File: rtl/fetch_unit.sv
// Purpose     : instruction-fetch stage with program counter and IF/ID pipeline register.
// Latency     : IF/ID updates at the edge that ends the cycle imem_ready is seen (1 instr/cycle with zero-wait memory).
// Backpressure: freeze holds IF/ID; a word returning under freeze is parked in hold_reg and fetching pauses.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-low reset
//   freeze              : hazard stall, IF/ID keeps its contents
//   branch_taken/_address : EXE redirect; flushes IF/ID, retargets the PC
//   imem_req/addr       : fetch request, address held stable until imem_ready
//   imem_ready/rdata    : one-cycle completion pulse with the fetched word
//   PC/Instruction/valid: IF/ID register towards decode (valid=0 is a bubble)

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        valid
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc_reg;
  logic [31:0] hold_reg;
  logic [31:0] tgt_reg;
  logic        redir;
  logic [31:0] pc_next;

  // 32-bit add wraps naturally, so the top word rolls over to 0.
  assign pc_next = pc_reg + STEP;

  // A request is outstanding whenever we are fetching; the reset term
  // keeps the memory interface quiet for as long as rst is held low.
  assign imem_req  = rst & (state == FETCH);
  assign imem_addr = pc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      pc_reg      <= RESET_PC;
      hold_reg    <= '0;
      tgt_reg     <= '0;
      redir       <= 1'b0;
      PC          <= '0;
      Instruction <= '0;
      valid       <= 1'b0;
    end else if (branch_taken) begin
      // Branch wins over freeze and ready: flush IF/ID unconditionally.
      PC          <= '0;
      Instruction <= '0;
      valid       <= 1'b0;
      if (state == HOLD) begin
        // Parked word is on the wrong path; simply leaving HOLD drops it.
        pc_reg <= branch_address;
        state  <= FETCH;
      end else if (imem_ready) begin
        // The in-flight request completes now, so retarget directly.
        // This also supersedes any earlier pending redirect.
        pc_reg <= branch_address;
        redir  <= 1'b0;
      end else begin
        // Address must not move mid-request: remember the target and
        // throw away the word when it eventually arrives.
        tgt_reg <= branch_address;
        redir   <= 1'b1;
      end
    end else if (state == HOLD) begin
      if (!freeze) begin
        // pc_reg already advanced when the word was parked, so it is
        // exactly the held instruction's address + step.
        Instruction <= hold_reg;
        PC          <= pc_reg;
        valid       <= 1'b1;
        state       <= FETCH;
      end
    end else if (imem_ready) begin
      if (redir) begin
        // Wrong-path word from before the branch: discard it.
        pc_reg <= tgt_reg;
        redir  <= 1'b0;
        if (!freeze) begin
          PC          <= '0;
          Instruction <= '0;
          valid       <= 1'b0;
        end
      end else begin
        pc_reg <= pc_next;
        if (freeze) begin
          hold_reg <= imem_rdata;
          state    <= HOLD;
        end else begin
          Instruction <= imem_rdata;
          PC          <= pc_next;
          valid       <= 1'b1;
        end
      end
    end else if (!freeze) begin
      // Memory still busy: decode sees a bubble.
      PC          <= '0;
      Instruction <= '0;
      valid       <= 1'b0;
    end
  end

endmodule
